// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative 32-bit multiply/divide unit:
// operation encodings, FSM states and iteration count.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int ITERATIONS = 32;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start;
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, mthi, mtlo, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                    output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_iter.sv
// 64-bit accumulator/remainder datapath: one radix-2 shift-add (multiply)
// or restoring shift-subtract (divide) step per i_step cycle.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [31:0] i_a_mag,
    input  logic [31:0] i_b_mag,
    output logic [63:0] o_acc
);

    logic [63:0] r_acc;
    logic [31:0] r_opnd;

    logic [32:0] w_sum;
    logic [32:0] w_rem;
    logic [32:0] w_trial;
    logic [63:0] w_mul_next;
    logic [63:0] w_div_next;
    logic [63:0] w_next;

    always_comb begin
        w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
        w_mul_next = {w_sum, r_acc[31:1]};

        // Remainder shifted left with the next dividend bit; a borrow out of
        // bit 32 means the trial subtraction failed and the remainder is kept.
        w_rem      = r_acc[63:31];
        w_trial    = w_rem - {1'b0, r_opnd};
        w_div_next = w_trial[32] ? {w_rem[31:0],   r_acc[30:0], 1'b0}
                                 : {w_trial[31:0], r_acc[30:0], 1'b1};

        w_next     = i_is_div ? w_div_next : w_mul_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= 64'd0;
            r_opnd <= 32'd0;
        end else if (i_load) begin
            r_acc  <= {32'd0, i_a_mag};
            r_opnd <= i_b_mag;
        end else if (i_step) begin
            r_acc  <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: 32 CALC cycles
// on operand magnitudes followed by one FIX cycle for sign correction.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    state_e      r_state;
    state_e      w_next_state;
    logic [4:0]  r_cnt;
    op_e         r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_b_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_open;
    logic        w_accept;
    logic        w_move_ok;
    logic        w_busy;
    logic        w_done;
    logic        w_step;
    logic        w_is_div;
    logic        w_in_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [63:0] w_acc;
    logic        w_neg_res;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_open      = (r_state == IDLE) || (r_state == DONE);
    assign w_accept    = w_open && bus.start;
    assign w_move_ok   = w_open && !bus.start;
    assign w_in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_neg_a     = w_in_signed && bus.a[31];
    assign w_neg_b     = w_in_signed && bus.b[31];
    assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: if (bus.start) w_next_state = CALC;
            CALC: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == LAST_ITER) w_next_state = FIX;
            end
            FIX: begin
                w_busy       = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = bus.start ? CALC : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    muldiv_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_is_div (w_is_div),
        .i_a_mag  (mag32(bus.a, w_neg_a)),
        .i_b_mag  (mag32(bus.b, w_neg_b)),
        .o_acc    (w_acc)
    );

    // A zero divisor yields an all-ones quotient regardless of operand signs.
    always_comb begin
        w_neg_res = r_sign_a ^ r_sign_b;
        w_prod    = w_neg_res ? (64'd0 - w_acc) : w_acc;
        w_quo     = r_b_zero  ? 32'hFFFF_FFFF : mag32(w_acc[31:0], w_neg_res);
        w_rem     = mag32(w_acc[63:32], r_sign_a);
        w_res_hi  = w_is_div ? w_rem : w_prod[63:32];
        w_res_lo  = w_is_div ? w_quo : w_prod[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_op     <= OP_MULT;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op     <= bus.op;
                r_sign_a <= w_neg_a;
                r_sign_b <= w_neg_b;
                r_b_zero <= (bus.b == 32'd0);
                r_cnt    <= 5'd0;
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + 5'd1;
            end
            if (r_state == FIX) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_move_ok) begin
                if (bus.mthi) r_hi <= bus.wdata;
                if (bus.mtlo) r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO and start cycle are queued
// at launch and compared when done is seen.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned start_cyc;
    } exp_t;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];

    muldiv_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi", bus.hi, e.hi);
                check("lo", bus.lo, e.lo);
                check("latency", cyc - e.start_cyc, 64'd33);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where done is high.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int busy_n);
        logic [63:0] e;
        exp_t        x;
        logic [31:0] hi_before;
        logic [31:0] lo_before;
        bit          seen;
        seen      = 1'b0;
        busy_n    = 0;
        hi_before = bus.hi;
        lo_before = bus.lo;
        e         = model(op, a, b);
        x.hi      = e[63:32];
        x.lo      = e[31:0];
        x.start_cyc = cyc + 1;
        sb.push_back(x);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = op_e'(2'($urandom_range(0, 3)));
        for (int i = 1; i <= 60 && !seen; i++) begin
            if (i == 1) begin
                check("done_after_start", bus.done, 64'd0);
                check("hi_hold_at_start", bus.hi, hi_before);
                check("lo_hold_at_start", bus.lo, lo_before);
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.busy === 1'b1) busy_n++;
                if (disturb && i == 6) begin
                    bus.start = 1'b1;
                    bus.op    = OP_DIV;
                    bus.a     = 32'd99;
                    bus.b     = 32'd3;
                    bus.mtlo  = 1'b1;
                    bus.wdata = 32'h0000_1234;
                end
                if (disturb && i == 7) begin
                    check("mtlo_in_calc", bus.lo, lo_before);
                    check("busy_in_calc", bus.busy, 64'd1);
                    bus.start = 1'b0;
                    bus.mtlo  = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        vec_t vecs[$];
        int   nb;
        logic [31:0] hold;

        vecs = '{
            '{OP_MULT,  32'hFFFF_FFFD, 32'd7},
            '{OP_DIV,   32'hFFFF_FFF9, 32'd2},
            '{OP_DIVU,  32'd100,       32'd7},
            '{OP_DIVU,  32'd100,       32'd0},
            '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF},
            '{OP_DIV,   32'hFFFF_FFF9, 32'd0},
            '{OP_MULT,  32'h8000_0000, 32'h8000_0000},
            '{OP_DIV,   32'd7,         32'hFFFF_FFFE},
            '{OP_DIVU,  32'hFFFF_FFFF, 32'd1}
        };

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 64'd0);
        check("rst_done", bus.done, 64'd0);
        check("rst_hi",   bus.hi,   64'd0);
        check("rst_lo",   bus.lo,   64'd0);
        rst = 1'b0;

        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mtlo_idle", bus.lo, 64'h1234);
        check("mtlo_idle_hi", bus.hi, 64'd0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, nb);
        check("busy_cycles", nb, 64'd33);
        @(negedge clk);
        check("done_single", bus.done, 64'd0);
        check("multu_max_hi", bus.hi, 64'hFFFF_FFFE);
        check("multu_max_lo", bus.lo, 64'h0000_0001);

        foreach (vecs[k]) begin
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, 1'b0, nb);
            check("busy_cycles", nb, 64'd33);
            @(negedge clk);
        end

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, nb);
        @(negedge clk);
        check("mult_neg_hi", bus.hi, 64'hFFFF_FFFF);
        check("mult_neg_lo", bus.lo, 64'hFFFF_FFEB);

        run_op(OP_MULTU, 32'd6, 32'd7, 1'b1, nb);
        check("busy_cycles_disturbed", nb, 64'd33);

        // back-to-back: start accepted in DONE
        run_op(OP_DIVU, 32'd1000, 32'd9, 1'b0, nb);
        run_op(OP_MULT, 32'hFFFF_FF00, 32'h0000_0100, 1'b0, nb);
        @(negedge clk);

        hold      = bus.hi;
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        run_op(OP_MULTU, 32'd11, 32'd13, 1'b0, nb);
        @(negedge clk);
        check("start_beats_mthi_hi", bus.hi, 64'd0);
        check("start_beats_mthi_lo", bus.lo, 64'd143);

        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi_both", bus.hi, 64'hCAFE_F00D);
        check("mtlo_both", bus.lo, 64'hCAFE_F00D);

        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", bus.busy, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midcalc_rst_busy", bus.busy, 64'd0);
        check("midcalc_rst_done", bus.done, 64'd0);
        check("midcalc_rst_hi",   bus.hi,   64'd0);
        check("midcalc_rst_lo",   bus.lo,   64'd0);
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.wdata = 32'h5555_AAAA;
        @(negedge clk);
        check("rst_ignores_start", bus.busy, 64'd0);
        check("rst_ignores_mthi",  bus.hi,   64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        @(negedge clk);
        check("idle_after_rst", bus.busy, 64'd0);

        run_op(OP_MULTU, 32'd3, 32'd5, 1'b0, nb);
        @(negedge clk);
        check("post_rst_hi", bus.hi, 64'd0);
        check("post_rst_lo", bus.lo, 64'd15);

        for (int r = 0; r < 8; r++) begin
            run_op(op_e'(2'(r)), $urandom, (r == 6) ? 32'($urandom_range(1, 50)) : $urandom, 1'b0, nb);
            @(negedge clk);
        end

        check("scoreboard_empty", sb.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 start  input  1  request to launch an operation; sampled only in IDLE or DONE.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  input  32  rs operand, driven from register-file read port 1.
REQ-008 b  input  32  rt operand, driven from register-file read port 2.
REQ-009 mthi  input  1  write wdata to HI.
REQ-010 mtlo  input  1  write wdata to LO.
REQ-011 wdata  input  32  data for mthi/mtlo.
REQ-012 busy  output  1  high while in CALC or FIX.
REQ-013 done  output  1  high for exactly one cycle, in state DONE.
REQ-014 hi  output  32  HI register; MULT high word, DIV remainder.
REQ-015 lo  output  32  LO register; MULT low word, DIV quotient.

Function
REQ-016 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
- IDLE or DONE, start=1 -> CALC.
- IDLE, start=0 -> IDLE.
- DONE, start=0 -> IDLE.
- CALC, after 32 iterations -> FIX.
- FIX -> DONE, unconditionally.
REQ-017 On the edge accepting start, the block SHALL latch op, |a| and |b|, and the sign flags; a sign flag is set only for MULT or DIV with a negative operand.
REQ-018 In CALC, each cycle SHALL perform one radix-2 step on the unsigned magnitudes:
- multiply: shift-add;
- divide: restoring shift-subtract.
A 5-bit iteration counter runs from 0 to 31.
REQ-019 In FIX, the block SHALL apply sign correction:
- MULT: negate the 64-bit product if sign(a) XOR sign(b).
- DIV: negate the quotient if the signs differ; give the remainder the sign of a.
REQ-020 hi and lo SHALL be updated on the FIX->DONE edge, exactly 33 rising edges after the edge that accepted start; done=1 during the following cycle.
REQ-021 Divide-by-zero (b=0) SHALL keep the normal latency and produce lo=0xFFFFFFFF, hi=a, for both DIV and DIVU.
REQ-022 DIV with a=0x80000000 and b=0xFFFFFFFF SHALL produce lo=0x80000000, hi=0.
REQ-023 start asserted in CALC or FIX SHALL be ignored, with no queueing.
REQ-024 mthi and mtlo SHALL take effect on the next edge, only in IDLE or DONE, and SHALL be ignored in CALC or FIX.
REQ-025 If start and mthi/mtlo are asserted in the same cycle, start SHALL win and the move SHALL be dropped.
REQ-026 If mthi and mtlo are asserted together, both registers SHALL be written with wdata.
REQ-027 A start accepted in DONE SHALL begin a new operation back-to-back; done drops on the next cycle.
REQ-028 a, b and op SHALL be don't-care after the start edge.

Reset
REQ-029 rst=1 at a rising edge SHALL force, from any state including mid-CALC:
- state=IDLE;
- hi=0, lo=0, counter=0;
- busy=0, done=0.
REQ-030 While rst=1, start, mthi and mtlo SHALL be ignored.

Structure
REQ-031 Package muldiv_pkg SHALL hold:
- the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
- the FSM state enum;
- the constant ITERATIONS=32.
REQ-032 A single sub-module, muldiv_iter, SHALL hold the 64-bit accumulator/remainder datapath and its one-step logic. The FSM, sign handling and the HI/LO registers SHALL remain in muldiv_unit.

Verification
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 33 edges after start; busy high for 33 cycles.
REQ-034 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); and DIVU a=100, b=7 -> lo=14, hi=2.
REQ-036 Corner divides:
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 Pulse rst on CALC iteration 10 -> next cycle busy=0, done=0, hi=lo=0; a subsequent MULTU 3*5 -> lo=15, hi=0.
REQ-038 Busy-state stimulus:
- start with different operands at iteration 5 -> ignored, original result delivered.
- mtlo wdata=0x1234 during CALC -> ignored.
- mtlo wdata=0x1234 in IDLE -> lo=0x1234 next cycle.
